// File: rtl/pl_branch_predictor.sv
// pl_branch_predictor
//   Dynamic branch predictor for the 5-stage core: a direct-mapped branch
//   target buffer with one 2-bit saturating counter per entry. The fetch PC
//   is looked up combinationally; the execute stage trains the table and
//   gets back the mispredict flag and the PC to redirect fetch to.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   PCF                  fetch-stage PC
//   predict_taken        fetch prediction (combinational)
//   predict_target       next fetch PC (combinational)
//   update_en            execute-stage instruction is a resolved branch/jump
//   PCE                  execute-stage PC
//   taken_E, target_E    actual outcome and taken target
//   predicted_E          prediction that travelled with the instruction
//   predicted_target_E   predicted next PC that travelled with the instruction
//   mispredict           redirect required (combinational)
//   correct_pc           redirect PC (combinational)
//   branch_count         resolved branches seen (saturating)
//   mispredict_count     mispredicts seen (saturating)
module pl_branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCF,
   output logic                  predict_taken,
   output logic [DATA_WIDTH-1:0] predict_target,
   input  logic                  update_en,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic                  taken_E,
   input  logic [DATA_WIDTH-1:0] target_E,
   input  logic                  predicted_E,
   input  logic [DATA_WIDTH-1:0] predicted_target_E,
   output logic                  mispredict,
   output logic [DATA_WIDTH-1:0] correct_pc,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispredict_count
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;

   logic                  valid_q  [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];

   logic [IDX-1:0]   idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   logic             hit_f, hit_e;

   // Instructions are word aligned, so the low two PC bits carry no index
   // or tag information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] stat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   assign idx_f = PCF[IDX+1:2];
   assign tag_f = PCF[DATA_WIDTH-1:IDX+2];
   assign idx_e = PCE[IDX+1:2];
   assign tag_e = PCE[DATA_WIDTH-1:IDX+2];

   assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

   // Fetch lookup reads the registered table, so a same-cycle update to the
   // same entry is only seen from the following cycle.
   assign predict_taken  = hit_f && ctr_q[idx_f][1];
   assign predict_target = predict_taken ? target_q[idx_f] : PCF + DATA_WIDTH'(4);

   // A taken branch that was predicted taken can still mispredict if the
   // carried target is stale (e.g. jalr to a new address).
   assign mispredict = update_en &&
                       ((taken_E != predicted_E) ||
                        (taken_E && (target_E != predicted_target_E)));
   assign correct_pc = taken_E ? target_E : PCE + DATA_WIDTH'(4);

   // Control state: valid bits, direction counters, statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (update_en) begin
         branch_count <= stat_inc(branch_count);
         if (mispredict) begin
            mispredict_count <= stat_inc(mispredict_count);
         end
         if (hit_e) begin
            ctr_q[idx_e] <= taken_E ? ctr_inc(ctr_q[idx_e]) : ctr_dec(ctr_q[idx_e]);
         end else if (taken_E) begin
            // Allocation overwrites whatever alias held this slot.
            valid_q[idx_e] <= 1'b1;
            ctr_q[idx_e]   <= 2'b10;
         end
      end
   end

   // Tag and target storage needs no reset: it is qualified by valid_q.
   // A taken update writes both on hit (tag unchanged) and on allocation.
   always_ff @(posedge clk) begin
      if (!rst && update_en && taken_E) begin
         tag_q[idx_e]    <= tag_e;
         target_q[idx_e] <= target_E;
      end
   end

endmodule

// File: tb/tb_pl_branch_predictor.sv
module tb_pl_branch_predictor;

   localparam int ENT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] PCF = '0;
   logic        update_en = 1'b0;
   logic [31:0] PCE = '0;
   logic        taken_E = 1'b0;
   logic [31:0] target_E = '0;
   logic        predicted_E = 1'b0;
   logic [31:0] predicted_target_E = '0;

   logic        predict_taken, mispredict;
   logic [31:0] predict_target, correct_pc, branch_count, mispredict_count;
   logic        pt2, mp2;
   logic [31:0] ptg2, cpc2;
   logic [1:0]  bc2, mc2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pl_branch_predictor #(.DATA_WIDTH(32), .ENTRIES(ENT), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .PCF(PCF), .predict_taken(predict_taken),
      .predict_target(predict_target), .update_en(update_en), .PCE(PCE),
      .taken_E(taken_E), .target_E(target_E), .predicted_E(predicted_E),
      .predicted_target_E(predicted_target_E), .mispredict(mispredict),
      .correct_pc(correct_pc), .branch_count(branch_count),
      .mispredict_count(mispredict_count));

   // Narrow-counter instance sharing the same stimulus, for saturation.
   pl_branch_predictor #(.DATA_WIDTH(32), .ENTRIES(ENT), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .PCF(PCF), .predict_taken(pt2),
      .predict_target(ptg2), .update_en(update_en), .PCE(PCE),
      .taken_E(taken_E), .target_E(target_E), .predicted_E(predicted_E),
      .predicted_target_E(predicted_target_E), .mispredict(mp2),
      .correct_pc(cpc2), .branch_count(bc2), .mispredict_count(mc2));

   // ---------------- behavioural model ----------------
   bit          mv   [ENT];
   logic [31:0] mtag [ENT];
   logic [31:0] mtgt [ENT];
   int          mctr [ENT];
   longint      mbc, mmc;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % ENT);
   endfunction

   function automatic logic [31:0] m_tag(input logic [31:0] pc);
      return pc / (4 * ENT);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return mv[m_idx(pc)] && (mtag[m_idx(pc)] == m_tag(pc));
   endfunction

   function automatic bit m_ptaken(input logic [31:0] pc);
      return m_hit(pc) && (mctr[m_idx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
      logic [31:0] nxt;
      nxt = pc + 32'd4;
      return m_ptaken(pc) ? mtgt[m_idx(pc)] : nxt;
   endfunction

   function automatic bit m_misp();
      if (!update_en) return 1'b0;
      return (taken_E != predicted_E) || (taken_E && (target_E != predicted_target_E));
   endfunction

   function automatic logic [31:0] m_cpc();
      logic [31:0] nxt;
      nxt = PCE + 32'd4;
      return taken_E ? target_E : nxt;
   endfunction

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clock();
      int i;
      if (rst) begin
         for (int k = 0; k < ENT; k++) begin mv[k] = 0; mctr[k] = 1; end
         mbc = 0; mmc = 0;
      end else if (update_en) begin
         if (m_misp()) mmc = mmc + 1;
         mbc = mbc + 1;
         i = m_idx(PCE);
         if (m_hit(PCE)) begin
            if (taken_E) begin
               mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
               mtgt[i] = target_E;
            end else begin
               mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
            end
         end else if (taken_E) begin
            mv[i] = 1; mtag[i] = m_tag(PCE); mtgt[i] = target_E; mctr[i] = 2;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_clock();
      #2;
   endtask

   task automatic idle();
      update_en = 1'b0;
      taken_E = 1'b0;
      predicted_E = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                      input logic pe, input logic [31:0] pte);
      update_en = 1'b1; PCE = pce; taken_E = tk; target_E = tgt;
      predicted_E = pe; predicted_target_E = pte;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; idle();
      tick(); tick();
      rst = 1'b0; PCF = 32'h40; #1;
      n_checks++;
      if (predict_taken !== 1'b0) begin n_fail++;
         $display("FAIL reset_ptaken actual=%0b required=0", predict_taken); end
      n_checks++;
      if (predict_target !== 32'h44) begin n_fail++;
         $display("FAIL reset_ptarget actual=%h required=00000044", predict_target); end
      n_checks++;
      if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || bc2 !== 2'd0 || mc2 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_counts actual=%0d/%0d/%0d/%0d required=0/0/0/0",
                  branch_count, mispredict_count, bc2, mc2); end
      n_checks++;
      if (mispredict !== 1'b0) begin n_fail++;
         $display("FAIL reset_misp actual=%0b required=0", mispredict); end
   endtask

   task automatic test_allocate();
      PCF = 32'h40;
      upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h44); #1;
      n_checks++;
      if (mispredict !== 1'b1 || correct_pc !== 32'h10) begin n_fail++;
         $display("FAIL alloc_misp actual=%0b/%h required=1/00000010", mispredict, correct_pc); end
      tick(); idle(); #1;
      n_checks++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h10) begin n_fail++;
         $display("FAIL alloc_predict actual=%0b/%h required=1/00000010",
                  predict_taken, predict_target); end
   endtask

   task automatic test_training();
      bit tk  [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
      bit exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [31:0] et;
      PCF = 32'h40;
      for (int s = 0; s < 9; s++) begin
         upd(32'h40, tk[s], 32'h10, m_ptaken(32'h40), m_ptarget(32'h40));
         tick(); idle(); #1;
         et = exp[s] ? 32'h10 : 32'h44;
         n_checks++;
         if (predict_taken !== exp[s] || predict_target !== et) begin n_fail++;
            $display("FAIL train_step%0d actual=%0b/%h required=%0b/%h",
                     s, predict_taken, predict_target, exp[s], et); end
      end
   endtask

   task automatic test_aliasing();
      // Bring 0x40 back to taken so the alias has something to evict.
      upd(32'h40, 1'b1, 32'h10, m_ptaken(32'h40), m_ptarget(32'h40)); tick();
      upd(32'h80, 1'b1, 32'h200, m_ptaken(32'h80), m_ptarget(32'h80)); tick(); idle();
      PCF = 32'h80; #1;
      n_checks++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin n_fail++;
         $display("FAIL alias_new actual=%0b/%h required=1/00000200", predict_taken, predict_target); end
      PCF = 32'h40; #1;
      n_checks++;
      if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin n_fail++;
         $display("FAIL alias_evicted actual=%0b/%h required=0/00000044", predict_taken, predict_target); end
      upd(32'hC0, 1'b0, 32'h300, 1'b0, 32'hC4); tick(); idle();
      PCF = 32'h80; #1;
      n_checks++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin n_fail++;
         $display("FAIL alias_nt_miss actual=%0b/%h required=1/00000200", predict_taken, predict_target); end
   endtask

   task automatic test_rdw();
      PCF = 32'h40;
      upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h44); #1;
      n_checks++;
      if (predict_taken !== 1'b0) begin n_fail++;
         $display("FAIL rdw_same_cycle actual=%0b required=0", predict_taken); end
      tick(); idle(); #1;
      n_checks++;
      if (predict_taken !== 1'b1 || predict_target !== 32'h10) begin n_fail++;
         $display("FAIL rdw_next_cycle actual=%0b/%h required=1/00000010", predict_taken, predict_target); end
   endtask

   task automatic test_rst_priority();
      rst = 1'b1;
      upd(32'h44, 1'b1, 32'h80, 1'b0, 32'h48);
      tick(); rst = 1'b0; idle();
      PCF = 32'h40; #1;
      n_checks++;
      if (predict_taken !== 1'b0) begin n_fail++;
         $display("FAIL rstpri_0x40 actual=%0b required=0", predict_taken); end
      PCF = 32'h44; #1;
      n_checks++;
      if (predict_taken !== 1'b0 || predict_target !== 32'h48) begin n_fail++;
         $display("FAIL rstpri_0x44 actual=%0b/%h required=0/00000048", predict_taken, predict_target); end
      n_checks++;
      if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin n_fail++;
         $display("FAIL rstpri_counts actual=%0d/%0d required=0/0", branch_count, mispredict_count); end
   endtask

   task automatic test_stats();
      upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104); tick();
      upd(32'h104, 1'b0, 32'h0, 1'b0, 32'h108); tick();
      upd(32'h108, 1'b1, 32'h300, 1'b0, 32'h10C); tick(); idle(); #1;
      n_checks++;
      if (branch_count !== 32'd3 || mispredict_count !== 32'd1) begin n_fail++;
         $display("FAIL stats_3_1 actual=%0d/%0d required=3/1", branch_count, mispredict_count); end
      upd(32'h108, 1'b1, 32'h10, 1'b1, 32'h14); #1;
      n_checks++;
      if (mispredict !== 1'b1 || correct_pc !== 32'h10) begin n_fail++;
         $display("FAIL stats_target_misp actual=%0b/%h required=1/00000010", mispredict, correct_pc); end
      tick();
      upd(32'h10C, 1'b0, 32'h0, 1'b0, 32'h110); #1;
      n_checks++;
      if (mispredict !== 1'b0 || correct_pc !== 32'h110) begin n_fail++;
         $display("FAIL stats_nt_ok actual=%0b/%h required=0/00000110", mispredict, correct_pc); end
      tick(); idle(); #1;
      n_checks++;
      if (branch_count !== 32'd5 || mispredict_count !== 32'd2) begin n_fail++;
         $display("FAIL stats_5_2 actual=%0d/%0d required=5/2", branch_count, mispredict_count); end
      n_checks++;
      if (bc2 !== 2'd3 || mc2 !== 2'd2) begin n_fail++;
         $display("FAIL stats_sat2 actual=%0d/%0d required=3/2", bc2, mc2); end
      rst = 1'b1; tick(); rst = 1'b0; #1;
      n_checks++;
      if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || bc2 !== 2'd0 || mc2 !== 2'd0) begin
         n_fail++;
         $display("FAIL stats_rst actual=%0d/%0d/%0d/%0d required=0/0/0/0",
                  branch_count, mispredict_count, bc2, mc2); end
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
      return 32'h1000 + 32'(4 * $urandom_range(0, 39));
   endfunction

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         PCF = rand_pc();
         update_en = $urandom_range(0, 3) != 0;
         PCE = rand_pc();
         taken_E = $urandom_range(0, 1);
         target_E = (taken_E && $urandom_range(0, 1)) ? m_ptarget(PCE) : rand_pc();
         if ($urandom_range(0, 1) != 0) begin
            predicted_E = m_ptaken(PCE); predicted_target_E = m_ptarget(PCE);
         end else begin
            predicted_E = $urandom_range(0, 1); predicted_target_E = rand_pc();
         end
         #1;
         n_checks++;
         if (predict_taken !== m_ptaken(PCF) || predict_target !== m_ptarget(PCF)) begin n_fail++;
            $display("FAIL rand_predict c=%0d pc=%h actual=%0b/%h required=%0b/%h", c, PCF,
                     predict_taken, predict_target, m_ptaken(PCF), m_ptarget(PCF)); end
         n_checks++;
         if (mispredict !== m_misp() || correct_pc !== m_cpc()) begin n_fail++;
            $display("FAIL rand_misp c=%0d actual=%0b/%h required=%0b/%h", c,
                     mispredict, correct_pc, m_misp(), m_cpc()); end
         n_checks++;
         if (branch_count !== 32'(mbc) || mispredict_count !== 32'(mmc) ||
             bc2 !== 2'(sat(mbc, 3)) || mc2 !== 2'(sat(mmc, 3))) begin n_fail++;
            $display("FAIL rand_counts c=%0d actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d", c,
                     branch_count, mispredict_count, bc2, mc2, mbc, mmc, sat(mbc, 3), sat(mmc, 3)); end
         tick();
      end
      rst = 1'b0; idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < ENT; k++) begin mv[k] = 0; mctr[k] = 1; mtag[k] = '0; mtgt[k] = '0; end
      mbc = 0; mmc = 0;
      test_reset();
      test_allocate();
      test_training();
      test_aliasing();
      test_rdw();
      test_rst_priority();
      test_stats();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pl_branch_predictor.md
Name: pl_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipelined core.
- Replaces static "predict not taken, flush on PCSrcE" with a direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating counters.
- Looked up combinationally with the fetch PC; trained from the execute stage.
- Drives mispredict and the correct redirect PC to the PCSrc mux and hazard unit, plus saturating performance counters.

Parameters:
DATA_WIDTH, 32, width of PCs and targets
ENTRIES, 16, number of BTB entries; power of two, >= 2; IDX = log2(ENTRIES)
CNT_WIDTH, 32, width of the branch and mispredict statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
PCF  in  DATA_WIDTH  fetch-stage PC
predict_taken  out  1  fetch prediction (combinational)
predict_target  out  DATA_WIDTH  next fetch PC (combinational)
update_en  in  1  execute-stage instruction is a valid, unflushed branch/jal/jalr
PCE  in  DATA_WIDTH  execute-stage PC
taken_E  in  1  actual outcome
target_E  in  DATA_WIDTH  actual taken target (PCaddIMM or ALU result for jalr)
predicted_E  in  1  predict_taken value carried down the pipe with this instruction
predicted_target_E  in  DATA_WIDTH  predict_target carried down the pipe
mispredict  out  1  redirect required (combinational)
correct_pc  out  DATA_WIDTH  redirect PC (combinational)
branch_count  out  CNT_WIDTH  number of update_en cycles
mispredict_count  out  CNT_WIDTH  number of mispredict cycles

Behaviour:
- Reset and clocking: one clock; rst is synchronous active-high.
- Address split: index = PC[IDX+1:2]; tag = PC[DATA_WIDTH-1:IDX+2]. PC[1:0] is ignored.
- Entry state: valid (1), tag, target (DATA_WIDTH), ctr (2 bits; 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup (combinational, PCF):
  - hit = valid[idx] & tag match.
  - predict_taken = hit & ctr[1].
  - predict_target = predict_taken ? target[idx] : PCF+4 (modulo 2^DATA_WIDTH).
- Mispredict (combinational):
  - mispredict = update_en & ((taken_E != predicted_E) | (taken_E & target_E != predicted_target_E)).
  - correct_pc = taken_E ? target_E : PCE+4.
  - mispredict is 0 whenever update_en = 0.
- Update (on the clock edge when update_en=1 and rst=0; index and tag taken from PCE):
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= target_E.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias: valid=1, tag, target=target_E, ctr=10.
  - Miss, not taken: no state change.
- Statistics:
  - branch_count +1 on each update_en cycle.
  - mispredict_count +1 on each mispredict cycle.
  - Both saturate at all-ones; no wrap.
- Read-during-write: if PCF and PCE map to the same entry in one cycle, the lookup returns pre-update contents; the new state is visible from the next cycle.
- Reset values: all valid=0; all ctr=01; targets and tags don't-care; branch_count=0; mispredict_count=0. As a result, after reset predict_taken=0 and predict_target=PCF+4.
- rst mid-operation: takes priority over update_en in the same cycle; the update is discarded and tables and counters clear on that edge.
- Stall: stallF does not affect this block; the pipeline must ensure update_en is asserted exactly once per resolved instruction (deasserted on flushE bubbles).
- Latency: lookup 0 cycles; training visible 1 cycle after the update edge.

Test Plan:
1. Reset, then PCF=0x40 -> predict_taken=0, predict_target=0x44; both counters 0.
2. update_en=1, PCE=0x40, taken_E=1, target_E=0x10, predicted_E=0 -> mispredict=1, correct_pc=0x10. Next cycle PCF=0x40 -> predict_taken=1, predict_target=0x10 (ctr=10).
3. Training 0x40 from ctr=10:
   - not-taken -> ctr 01; PCF=0x40 predicts 0, target 0x44.
   - second not-taken -> 00.
   - third not-taken -> stays 00.
   - two taken -> 10, predicts taken again.
   - taken twice more -> 11; one not-taken -> still predicts taken.
4. Aliasing: after entry 0 trained for 0x40, update PCE=0x80 (index 0, tag 2) taken to 0x200 -> PCF=0x80 predicts 0x200; PCF=0x40 misses, predict_taken=0. Not-taken update at PCE=0xC0 (miss) -> no change.
5. Same cycle, PCF=PCE=0x40, allocating taken update -> predict_taken=0 that cycle, 1 the next. Same cycle, rst=1 with update_en=1 -> update discarded; PCF=0x40 misses afterwards.
6. Statistics: 3 updates with exactly 1 mispredict -> branch_count=3, mispredict_count=1. Taken with predicted_E=1 but predicted_target_E=0x14 vs target_E=0x10 -> mispredict=1. With CNT_WIDTH=2, 5 updates -> branch_count=3 (saturated). rst -> both 0.
